// File: rtl/food_seller_pkg.sv
// Shared types and helpers for the food seller controller.
// The FSM state enum and the item price function live here; all sizing
// parameters stay on the modules that use them.
package food_seller_pkg;

  // Controller states; IDLE and CREDIT differ only in whether credit is zero.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  // Price of item idx: base + idx * step, evaluated at 32 bits so that the
  // comparison against credit never truncates a large price.
  function automatic logic [31:0] price(input logic [31:0] idx,
                                        input logic [31:0] base,
                                        input logic [31:0] step);
    return base + idx * step;
  endfunction

endpackage

// File: rtl/food_stock_bank.sv
// Per-item stock counters with registered sold-out flags.
// Optional feature macro: FOOD_SELLER_RESTOCK_EN adds a saturating restock
// port; without it stock only counts down from the reset value.
module food_stock_bank #(
  parameter int NUM_ITEMS  = 4,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  localparam int IDX_W     = $clog2(NUM_ITEMS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_en,
  input  logic [IDX_W-1:0]     dec_item,
`ifdef FOOD_SELLER_RESTOCK_EN
  input  logic                 restock_en,
  input  logic [IDX_W-1:0]     restock_item,
  input  logic [STOCK_W-1:0]   restock_qty,
`endif
  output logic [NUM_ITEMS-1:0] sold_out
);

  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
  // Reset stock, clamped to what the counter can hold.
  localparam logic [STOCK_W-1:0] INIT_SAT =
    (INIT_STOCK >= (1 << STOCK_W)) ? STOCK_MAX : STOCK_W'(INIT_STOCK);

  logic [STOCK_W-1:0] stock     [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_nxt [NUM_ITEMS];

  // Unsigned add that pins at the counter maximum instead of wrapping.
  function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                 input logic [STOCK_W-1:0] b);
    logic [STOCK_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STOCK_W] ? STOCK_MAX : sum[STOCK_W-1:0];
  endfunction

  // Next stock per item: restock first, then the vend decrement.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_nxt[i] = stock[i];
`ifdef FOOD_SELLER_RESTOCK_EN
      if (restock_en && (restock_item == IDX_W'(i)))
        stock_nxt[i] = sat_add(stock_nxt[i], restock_qty);
`endif
      // The controller never vends a sold-out item; the zero guard only
      // keeps the counter from wrapping if that were ever violated.
      if (dec_en && (dec_item == IDX_W'(i)) && (stock_nxt[i] != '0))
        stock_nxt[i] = stock_nxt[i] - STOCK_W'(1);
    end
  end

  // Stock registers and sold-out flags, both loaded from the next-stock value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock[i]    <= INIT_SAT;
        sold_out[i] <= (INIT_SAT == '0);
      end
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock[i]    <= stock_nxt[i];
        sold_out[i] <= (stock_nxt[i] == '0);
      end
    end
  end

endmodule

// File: rtl/food_seller_ctrl.sv
// Food vending controller: accepts coins, vends priced items, returns change.
// One request is served per cycle (cancel > selection > coin); a losing coin
// is rejected. Optional feature macro: FOOD_SELLER_RESTOCK_EN (restock port,
// accepted only while idle).
module food_seller_ctrl
  import food_seller_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  parameter int BASE_PRICE = 10,
  parameter int PRICE_STEP = 5,
  localparam int IDX_W     = $clog2(NUM_ITEMS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coin_valid,
  input  logic [3:0]           coin_value,
  input  logic                 sel_valid,
  input  logic [IDX_W-1:0]     sel_item,
  input  logic                 cancel,
`ifdef FOOD_SELLER_RESTOCK_EN
  input  logic                 restock_valid,
  input  logic [IDX_W-1:0]     restock_item,
  input  logic [STOCK_W-1:0]   restock_qty,
`endif
  output logic                 dispense_valid,
  output logic [IDX_W-1:0]     dispense_item,
  output logic                 change_valid,
  output logic [CREDIT_W-1:0]  change_value,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy,
  output logic                 reject
);

  state_t                state;
  state_t                state_nxt;
  logic [CREDIT_W-1:0]   credit_nxt;
  logic                  disp_vld_nxt;
  logic [IDX_W-1:0]      disp_item_nxt;
  logic                  chg_vld_nxt;
  logic [CREDIT_W-1:0]   chg_val_nxt;
  logic                  reject_nxt;
  logic                  dec_en;
  logic [CREDIT_W:0]     coin_sum;
  logic [31:0]           sel_price;
  logic                  sel_in_range;
  logic                  sel_ok;
`ifdef FOOD_SELLER_RESTOCK_EN
  logic                  restock_en;
`endif

  // One extra bit catches credit overflow on a coin.
  assign coin_sum     = {1'b0, credit} + {{(CREDIT_W-3){1'b0}}, coin_value};
  assign sel_price    = price(32'(sel_item), 32'(BASE_PRICE), 32'(PRICE_STEP));
  assign sel_in_range = (32'(sel_item) < 32'(NUM_ITEMS));
  // The range test short-circuits the sold_out lookup for unused indices.
  assign sel_ok       = sel_in_range && !sold_out[sel_item] &&
                        (32'(credit) >= sel_price);
  assign busy         = (state == ST_DISPENSE) || (state == ST_CHANGE);

`ifdef FOOD_SELLER_RESTOCK_EN
  assign restock_en   = restock_valid && (state == ST_IDLE);
`endif

  // Next-state, next-credit and next-pulse decode for the vending FSM.
  always_comb begin
    state_nxt     = state;
    credit_nxt    = credit;
    disp_vld_nxt  = 1'b0;
    disp_item_nxt = '0;
    chg_vld_nxt   = 1'b0;
    chg_val_nxt   = '0;
    reject_nxt    = 1'b0;
    dec_en        = 1'b0;
    case (state)
      ST_IDLE, ST_CREDIT: begin
        if (cancel && (state == ST_CREDIT)) begin
          // Credit stays visible during CHANGE and clears on the way out.
          state_nxt   = ST_CHANGE;
          chg_vld_nxt = 1'b1;
          chg_val_nxt = credit;
          reject_nxt  = coin_valid;
        end else if (sel_valid) begin
          if (sel_ok) begin
            state_nxt     = ST_DISPENSE;
            credit_nxt    = credit - sel_price[CREDIT_W-1:0];
            disp_vld_nxt  = 1'b1;
            disp_item_nxt = sel_item;
            dec_en        = 1'b1;
          end else begin
            reject_nxt = 1'b1;
          end
          if (coin_valid)
            reject_nxt = 1'b1;
        end else if (coin_valid) begin
          if (coin_sum[CREDIT_W]) begin
            reject_nxt = 1'b1;
          end else begin
            credit_nxt = coin_sum[CREDIT_W-1:0];
            // A zero-value coin leaves the machine idle.
            state_nxt  = (coin_sum == '0) ? ST_IDLE : ST_CREDIT;
          end
        end
      end
      ST_DISPENSE: begin
        reject_nxt = coin_valid;
        if (credit != '0) begin
          state_nxt   = ST_CHANGE;
          chg_vld_nxt = 1'b1;
          chg_val_nxt = credit;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        reject_nxt = coin_valid;
        credit_nxt = '0;
        state_nxt  = ST_IDLE;
      end
      default: begin
        state_nxt  = ST_IDLE;
        credit_nxt = '0;
      end
    endcase
`ifdef FOOD_SELLER_RESTOCK_EN
    if (restock_valid && (state != ST_IDLE))
      reject_nxt = 1'b1;
`endif
  end

  // FSM state and credit register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      credit <= '0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
    end
  end

  // Registered one-cycle pulses; values are forced to zero when not valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      dispense_valid <= 1'b0;
      dispense_item  <= '0;
      change_valid   <= 1'b0;
      change_value   <= '0;
      reject         <= 1'b0;
    end else begin
      dispense_valid <= disp_vld_nxt;
      dispense_item  <= disp_item_nxt;
      change_valid   <= chg_vld_nxt;
      change_value   <= chg_val_nxt;
      reject         <= reject_nxt;
    end
  end

  food_stock_bank #(
    .NUM_ITEMS  (NUM_ITEMS),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clk          (clk),
    .reset        (reset),
    .dec_en       (dec_en),
    .dec_item     (sel_item),
`ifdef FOOD_SELLER_RESTOCK_EN
    .restock_en   (restock_en),
    .restock_item (restock_item),
    .restock_qty  (restock_qty),
`endif
    .sold_out     (sold_out)
  );

endmodule

// File: doc/food_seller_ctrl.md
FOOD_SELLER_CTRL -- requirements
Module: food_seller_ctrl

Interface
REQ-001 SHALL have parameter NUM_ITEMS, default 4, the number of selectable food items (2..16).
REQ-002 SHALL have parameter CREDIT_W, default 8, the credit/change width in coin units.
REQ-003 SHALL have parameter STOCK_W, default 4, the per-item stock counter width.
REQ-004 SHALL have parameter INIT_STOCK, default 5, the stock of every item after reset.
REQ-005 SHALL have parameters BASE_PRICE, default 10, and PRICE_STEP, default 5; price(i) = BASE_PRICE + i*PRICE_STEP.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have ports coin_valid (input, 1) and coin_value (input, 4): a coin of coin_value units inserted this cycle.
REQ-009 SHALL have ports sel_valid (input, 1) and sel_item (input, $clog2(NUM_ITEMS)): an item request.
REQ-010 SHALL have port cancel, input, 1 bit: return all credit.
REQ-011 SHALL have ports dispense_valid (output, 1) and dispense_item (output, $clog2(NUM_ITEMS)): a one-cycle vend pulse.
REQ-012 SHALL have ports change_valid (output, 1) and change_value (output, CREDIT_W): a one-cycle change pulse.
REQ-013 SHALL have outputs credit (CREDIT_W), sold_out (NUM_ITEMS, one bit per item), busy (1), and reject (1, one-cycle pulse).

Function
REQ-014 SHALL implement the FSM states IDLE (credit==0), CREDIT, DISPENSE and CHANGE; DISPENSE and CHANGE each last exactly one cycle.
REQ-015 SHALL evaluate at most one request per cycle, with priority cancel > sel_valid > coin_valid; a coin that loses arbitration SHALL be rejected (reject=1 next cycle).
REQ-016 In IDLE/CREDIT, an accepted coin SHALL add coin_value to credit at the next edge; the state becomes CREDIT.
REQ-017 A coin that would make credit exceed 2^CREDIT_W-1 SHALL leave credit unchanged and pulse reject.
REQ-018 A selection with sold_out[sel_item]=1, credit<price(sel_item), or sel_item>=NUM_ITEMS SHALL pulse reject and change nothing else.
REQ-019 A valid selection at edge t SHALL give dispense_valid=1 with dispense_item in cycle t+1 (state DISPENSE), decrement that item's stock and subtract the price from credit.
REQ-020 After DISPENSE, a nonzero remainder SHALL give change_valid=1 with change_value=remainder in cycle t+2 (state CHANGE), then credit=0 and IDLE; a zero remainder SHALL go directly to IDLE.
REQ-021 cancel in CREDIT SHALL enter CHANGE with change_value=credit; cancel in IDLE SHALL be ignored.
REQ-022 busy SHALL be 1 exactly in DISPENSE/CHANGE; coins there SHALL be rejected, and sel_valid/cancel SHALL be ignored.
REQ-023 sold_out[i] SHALL equal (stock[i]==0), registered, and SHALL update in the cycle after the decrement.
REQ-024 change_value SHALL be 0 whenever change_valid=0, and dispense_item SHALL be 0 whenever dispense_valid=0.

Reset
REQ-025 reset SHALL force IDLE, credit=0, every stock=INIT_STOCK (saturated to STOCK_W), and all pulse outputs, busy and sold_out to 0 (unless INIT_STOCK=0).
REQ-026 reset asserted in DISPENSE or CHANGE SHALL abort the operation without emitting the pending pulse; the credit is lost.

Configuration
REQ-027 With macro FOOD_SELLER_RESTOCK_EN defined, the inputs restock_valid (1), restock_item (index width) and restock_qty (STOCK_W) SHALL exist; in IDLE, restock SHALL add the quantity to the item's stock, saturating at 2^STOCK_W-1; otherwise it SHALL pulse reject.
REQ-028 Without FOOD_SELLER_RESTOCK_EN, these ports SHALL be absent, and stock SHALL only decrease from INIT_STOCK.

Structure
REQ-029 The package food_seller_pkg SHALL hold the FSM state enum and a price(index) function; the parameters SHALL stay on the module.
REQ-030 The per-item stock counters, sold_out generation and (optional) restock SHALL live in the sub-module food_stock_bank.

Verification
REQ-031 Coins 5,5,5 then sel_item=1 (price 15) -> credit 15, dispense_valid with item 1 one cycle after the selection, no change_valid, IDLE.
REQ-032 Coins 9,9 then sel_item=0 (price 10) -> dispense item 0, then change_valid with value 8 in the next cycle, credit=0.
REQ-033 Credit 12 with sel_item=2 (price 20) -> reject pulse, credit stays 12; a later cancel -> change_value=12.
REQ-034 Six vends of item 3 with INIT_STOCK=5 -> sold_out[3]=1 after the fifth vend; the sixth selection is rejected.
REQ-035 Credit 250 plus a 9-unit coin with CREDIT_W=8 -> reject, credit 250; a coin and cancel in the same cycle -> change only, coin rejected.
REQ-036 reset asserted during DISPENSE -> no change_valid, credit=0, stock=INIT_STOCK; with FOOD_SELLER_RESTOCK_EN, a restock of qty 15 on stock 5 -> stock saturates at 15.
